// File: rtl/div_unit_pkg.sv
// Shared state codes and handshake constants for the iterative divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIVFREE   = 2'b00,
    DIVBYZERO = 2'b01,
    DIVON     = 2'b10,
    DIVEND    = 2'b11
  } div_state_e;

  localparam logic DIVRESULTREADY    = 1'b1;
  localparam logic DIVRESULTNOTREADY = 1'b0;
  localparam logic DIVSTART          = 1'b1;
  localparam logic DIVSTOP           = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: compare the shifted partial remainder with the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] diff;

  always_comb begin
    diff   = rem_i - {1'b0, divisor_i};
    qbit_o = (rem_i >= {1'b0, divisor_i});
    rem_o  = qbit_o ? diff : rem_i;
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider producing {remainder, quotient} with a start/ready handshake.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     dvd_q, dvd_d;   // dividend shifts out MSB-first, quotient shifts in
  logic [WIDTH:0]       rem_q, rem_d;
  logic [WIDTH-1:0]     dsr_q, dsr_d;
  logic                 qneg_q, qneg_d, rneg_q, rneg_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic [WIDTH-1:0]     a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH:0]       step_rem;
  logic                 step_qbit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     ({rem_q[WIDTH-1:0], dvd_q[WIDTH-1]}),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    ready_d  = DIVRESULTNOTREADY;
    result_d = '0;

    a_mag = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    b_mag = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    q_fix = qneg_q ? -dvd_q : dvd_q;
    r_fix = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    unique case (state_q)
      DIVFREE: begin
        if (start_i == DIVSTART && !annul_i) begin
          cnt_d = '0;
          if (opdata2_i == '0) begin
            // Divide-by-zero result is loaded directly; no sign correction applies.
            state_d = DIVBYZERO;
            dvd_d   = '1;
            rem_d   = {1'b0, opdata1_i};
            dsr_d   = '0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
          end else begin
            state_d = DIVON;
            dvd_d   = a_mag;
            rem_d   = '0;
            dsr_d   = b_mag;
            qneg_d  = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            rneg_d  = signed_i & opdata1_i[WIDTH-1];
          end
        end
      end
      DIVBYZERO: state_d = annul_i ? DIVFREE : DIVEND;
      DIVON: begin
        if (annul_i) begin
          state_d = DIVFREE;
        end else begin
          rem_d = step_rem;
          dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = DIVEND;
        end
      end
      DIVEND: begin
        // Leave only once the result has actually been presented.
        if (annul_i || (ready_q && start_i == DIVSTOP)) state_d = DIVFREE;
      end
      default: state_d = DIVFREE;
    endcase

    if (state_q == DIVEND && state_d == DIVEND) begin
      ready_d  = DIVRESULTREADY;
      result_d = {r_fix, q_fix};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DIVFREE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= DIVRESULTNOTREADY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q == DIVON) || (state_q == DIVBYZERO);

endmodule

// File: doc/div_unit.md
# div_unit

Iterative, parametrised divider that runs alongside the execute stage of the MIPS pipeline and produces the {hi, lo} pair for DIV/DIVU. It generalises the single-cycle hilo datapath to a multi-cycle unit with configurable width, signed and unsigned modes, divide-by-zero handling, annulment and a start/ready handshake. The execute stage holds the request and stalls the pipeline while `busy_o` is high, then forwards `result_o` to the hilo write path.

## Interface
- `WIDTH`, default 32: operand width in bits. Must be ≥ 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start_i`  in  1  request; held high by the requester until `ready_o` has been seen.
- `annul_i`  in  1  cancels the operation in flight (branch flush or exception).
- `signed_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at accept.
- `opdata1_i`  in  WIDTH  dividend; sampled at accept.
- `opdata2_i`  in  WIDTH  divisor; sampled at accept.
- `result_o`  out  2*WIDTH  {remainder, quotient}; the remainder goes to hi and the quotient to lo.
- `ready_o`  out  1  result valid.
- `busy_o`  out  1  operation in progress; stall request to pipeline control.

## Operation
- States:
  - FREE: idle.
  - BYZERO: divisor was zero.
  - ON: iterating.
  - END: result held.
- FREE behaviour:
  - With `start_i`=1 and `annul_i`=0, the unit accepts the request: it latches the mode and operands and clears the counter.
  - If the divisor is 0, the next state is BYZERO; otherwise it is ON.
- Signed mode setup at accept:
  - Both operands are converted to magnitudes (two's-complement negate when the MSB is 1).
  - The unit records two sign flags: quotient negative = sign1 XOR sign2; remainder negative = sign1.
- ON:
  - Restoring division, one quotient bit per cycle, MSB first, using a partial remainder of WIDTH+1 bits.
  - Each step: shift the partial remainder left by 1 and bring in the next dividend bit. If the result is ≥ the divisor, subtract the divisor and set the quotient bit to 1; otherwise set it to 0.
  - The counter has width $clog2(WIDTH+1) and counts 0..WIDTH-1. After WIDTH steps the state goes to END.
- END:
  - Apply the recorded sign corrections, drive `result_o`, and assert `ready_o`=1.
  - Stay in END while `start_i`=1; return to FREE on the cycle after `start_i`=0.
  - `result_o` is stable for the whole time in END.
- BYZERO: go to END with quotient = all ones and remainder = the original dividend, with no sign correction.
- Signed overflow (MIN / -1): the quotient is MIN (the negation wraps) and the remainder is 0. This falls out of the magnitude path naturally and needs no special case.
- `annul_i`:
  - In ON or BYZERO, the next state is FREE; `ready_o` is never asserted for that operation.
  - In FREE, it blocks acceptance.
  - In END, it forces FREE.
  - `annul_i` has priority over `start_i`.
- `busy_o` = 1 in ON and BYZERO, and 0 in FREE and END. The pipeline stalls until `ready_o` is seen.
- Outside END, `result_o` = 0 and `ready_o` = 0.

## Timing
- Reset values: state FREE, counter 0, `result_o` 0, `ready_o` 0, `busy_o` 0, all internal registers 0.
- Reset asserted mid-operation aborts it immediately. No result is produced.
- Latency, with the accept edge as edge 0:
  - Normal divide: `busy_o` is high from edge 0 to edge WIDTH; `ready_o` is first high after edge WIDTH+1.
  - Divide by zero: `ready_o` is high after edge 2.
- Back-to-back operations: a new request is accepted only in FREE. After `ready_o`, the requester drops `start_i` for at least one cycle.
- If `start_i` drops while in ON, the operation continues. The result is held in END and then dropped on the next cycle, because `start_i` is already 0.
- Changes to operands during ON are ignored.

## Structure
- Add the following to `macro.v`:
  - state codes `DIVFREE`, `DIVBYZERO`, `DIVON`, `DIVEND` (2 bits);
  - `DIVRESULTREADY`, `DIVRESULTNOTREADY`;
  - `DIVSTART`, `DIVSTOP`.
- Sub-module `div_step` (combinational): one restoring step, parametrised by WIDTH. Inputs: partial remainder and divisor. Outputs: the next partial remainder and the quotient bit.
- The unit is instantiated in `ex`. Its result feeds the existing hilo write path: hi_o = remainder, lo_o = quotient, whilo = 1 when `ready_o` is high.

## Test plan
- Unsigned, 100 / 7 at WIDTH=32 → `result_o` = {0x00000002, 0x0000000E}; `ready_o` rises exactly 33 edges after accept; `busy_o` is high for 32 cycles.
- Signed, -7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Divide by zero, 5 / 0 in unsigned mode → quotient 0xFFFFFFFF, remainder 0x00000005; `ready_o` is high 2 edges after accept; `busy_o` is high for 1 cycle.
- Annul: pulse `annul_i` on the 10th ON cycle → `busy_o` is 0 on the next cycle and `ready_o` never rises. A following unsigned 9 / 3 → quotient 3, remainder 0.
- Handshake: hold `start_i` high for 5 cycles after `ready_o` → `ready_o` and `result_o` stay stable. Drop `start_i` → FREE, and `result_o` = 0 one cycle later.
- Reset during ON → all outputs are 0 immediately, with no clock edge needed. A restart with WIDTH=8 (separate instance), unsigned 200 / 13 → quotient 15, remainder 5, ready after 9 edges.
